burst_ctrl: RTL
===============

Name: burst_ctrl

Overview:
Sequences one memory burst of up to 2^COUNTER_WIDTH beats against the MRAM interface. Latches a start command (base address, length, direction) and issues one request per beat over a req/ack handshake. Increments the address and beat counter, and stops when the beat count equals the burst length. Sits between the test-pattern/host logic and the MRAM access port, and replaces the free-running address-counter/stop-compare pairing.

Parameters:
ADDR_WIDTH, 16, width of the memory address bus
COUNTER_WIDTH, 4, width of burst_len and beat counter; max burst = 2^COUNTER_WIDTH beats

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle command strobe; honoured only when busy=0
rw_in  input  1  burst direction: 1 = write, 0 = read; sampled with start
base_addr  input  ADDR_WIDTH  first beat address; sampled with start
burst_len  input  COUNTER_WIDTH  beats minus one (0 = 1 beat); sampled with start
abort  input  1  terminate active burst early
mem_req  output  1  beat request to MRAM port
mem_we  output  1  write enable accompanying mem_req
mem_addr  output  ADDR_WIDTH  address of current beat
mem_ack  input  1  MRAM accepts current beat
busy  output  1  burst in progress (state != IDLE)
last_beat  output  1  combinational: mem_req & (beat_cnt == len_q)
beat_cnt  output  COUNTER_WIDTH  index of current beat, 0-based
done  output  1  one-cycle pulse at burst end
aborted  output  1  valid with done; 1 if burst ended by abort

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_req, mem_we, mem_addr, beat_cnt, busy, done, aborted all 0; len_q=0.
- States: IDLE, REQ, DONE.
- IDLE: on start=1, latch addr_q=base_addr, len_q=burst_len, we_q=rw_in, clear beat_cnt; next state REQ. start while busy=1 is ignored, no latch.
- REQ: mem_req=1, mem_we=we_q, mem_addr=addr_q. A beat completes on any cycle with mem_req=1 & mem_ack=1.
  - Beat completes and beat_cnt==len_q: go to DONE, aborted=0.
  - Beat completes, not last: beat_cnt+1, addr_q+1; stay in REQ with mem_req held high, so back-to-back beats run at one per cycle.
  - No ack: hold addr, we and beat_cnt stable. mem_req must not drop without ack except on abort.
- abort in REQ: abort without ack leads to DONE with aborted=1, and mem_req drops next cycle. abort together with ack counts the acked beat first. If that beat is the last, aborted=0. Otherwise aborted=1 and no further beats are issued.
- DONE: done=1 for exactly one cycle, mem_req=0; aborted held with done; next state IDLE. start during DONE is ignored.
- Latency: start at cycle T sets mem_req=1 at T+1. With mem_ack tied high, N=len+1 beats occupy T+1..T+N and done pulses at T+N+1. Minimum start-to-start spacing is N+2 cycles.
- Address arithmetic: addr_q increments modulo 2^ADDR_WIDTH, wrapping from all-ones to 0 with no error.
- beat_cnt never exceeds len_q. burst_len=2^COUNTER_WIDTH-1 gives the full 2^COUNTER_WIDTH beats with no counter overflow.
- Reset mid-burst: immediately returns to IDLE with outputs at reset values. No done pulse.
- abort in IDLE or DONE has no effect.

Optional Feature:
BURST_WRAP_EN — when defined, the burst address wraps within an aligned 2^COUNTER_WIDTH window. Upper ADDR_WIDTH-COUNTER_WIDTH bits stay fixed at base_addr, and the lower COUNTER_WIDTH bits increment modulo 2^COUNTER_WIDTH. Example: COUNTER_WIDTH=4, base 0x001E runs 0x1E, 0x1F, 0x10, 0x11. When undefined, the address increments linearly across the full ADDR_WIDTH.

Test Plan:
1. Reset, then start with base_addr=0x0100, burst_len=3, rw_in=1, mem_ack=1 -> mem_req high 4 cycles at 0x0100..0x0103, mem_we=1, last_beat on 0x0103, done one cycle later, aborted=0.
2. Read burst base 0x0040, burst_len=0, mem_ack asserted 3 cycles after req -> mem_addr held at 0x0040 for 3 cycles, single beat, done pulse, mem_we=0.
3. burst_len=7, mem_ack=1, abort asserted while beat_cnt=2 without ack (ack low that cycle) -> only beats 0,1 complete, mem_req drops, done=1 with aborted=1.
4. Start while busy with different base/len -> ignored. Original burst completes unchanged, with a second done absent.
5. base_addr=0xFFFE, burst_len=3, no BURST_WRAP_EN -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. With BURST_WRAP_EN: 0xFFFE, 0xFFFF, 0xFFF0, 0xFFF1.
6. Assert rst during beat 2 of an 8-beat burst -> mem_req, busy, beat_cnt, mem_addr go to 0 asynchronously, no done pulse, and the next start runs normally.

Source files
------------

// File: rtl/burst_ctrl.sv
// burst_ctrl: issues one req/ack memory burst of burst_len+1 beats.
// Define BURST_WRAP_EN to wrap addresses inside an aligned 2^COUNTER_WIDTH window.
module burst_ctrl #(
  parameter int ADDR_WIDTH    = 16,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     rw_in,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [COUNTER_WIDTH-1:0] burst_len,
  input  logic                     abort,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic                     last_beat,
  output logic [COUNTER_WIDTH-1:0] beat_cnt,
  output logic                     done,
  output logic                     aborted
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t                   state;
  logic [COUNTER_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0]    next_addr;
  logic                     fire;
  logic                     fin;
  assign fire      = mem_req & mem_ack;
  assign fin       = beat_cnt == len_q;
  assign last_beat = mem_req & fin;
`ifdef BURST_WRAP_EN
  assign next_addr = {mem_addr[ADDR_WIDTH-1:COUNTER_WIDTH], mem_addr[COUNTER_WIDTH-1:0] + 1'b1};
`else
  assign next_addr = mem_addr + 1'b1;
`endif
  // An acked last beat always wins over abort, so the burst counts as complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_we   <= rw_in;
          mem_addr <= base_addr;
          len_q    <= burst_len;
          beat_cnt <= '0;
          busy     <= 1'b1;
        end
        REQ: if ((fire && fin) || abort) begin
          state   <= DONE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
          aborted <= !(fire && fin);
        end else if (fire) begin
          beat_cnt <= beat_cnt + 1'b1;
          mem_addr <= next_addr;
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          aborted <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
